// File: rtl/decode_pkg.sv
// Shared opcode, ALU encodings and control-bundle decode for the ID stage.
// Pure definitions; no state.
package decode_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic       alusrc;
        logic       mem2reg;
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       branch;
        logic [1:0] aluop;
        logic [3:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] inst);
        ctrl_t c;
        c = '0;
        case (inst[6:0])
            OP_R: begin
                c.regwr    = 1'b1;
                c.aluop    = ALUOP_FUNCT;
                c.alu_ctrl = {inst[30], inst[14:12]};
            end
            OP_IMM: begin
                c.regwr    = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALUOP_FUNCT;
                // only shifts (funct3=101) use bit 30; elsewhere it is immediate data
                c.alu_ctrl = {inst[30] & (inst[14:12] == 3'b101), inst[14:12]};
            end
            OP_LD: begin
                c.alusrc   = 1'b1;
                c.mem2reg  = 1'b1;
                c.regwr    = 1'b1;
                c.memrd    = 1'b1;
                c.aluop    = ALUOP_ADD;
                c.alu_ctrl = ALU_ADD;
            end
            OP_ST: begin
                c.alusrc   = 1'b1;
                c.memwr    = 1'b1;
                c.aluop    = ALUOP_ADD;
                c.alu_ctrl = ALU_ADD;
            end
            OP_BR: begin
                c.branch   = 1'b1;
                c.aluop    = ALUOP_BR;
                c.alu_ctrl = ALU_SUB;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_ST) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 2R1W architectural register file, x0 hardwired to zero; reads are combinational.
// Optional write-through from the write port to the read ports under DECODE_WB_BYPASS_EN.
// No backpressure: writes always land on the clock edge.
module decode_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  rs1_addr,
    input  logic [RAW-1:0]  rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [RAW-1:0]  wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_en && (wr_addr != '0) && (wr_addr == rs1_addr)) rs1_data = wr_data;
        if (wr_en && (wr_addr != '0) && (wr_addr == rs2_addr)) rs2_data = wr_data;
`endif
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: regfile read, control/immediate decode, registered ID/EX output (macro: DECODE_WB_BYPASS_EN).
// Latency: 1 cycle in_inst -> out_*; one bubble per dependent load.
// Backpressure: holds everything while out_valid & !out_ready; flush clears ID/EX regardless.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RAW-1:0]  out_rs1,
    output logic [RAW-1:0]  out_rs2,
    output logic [RAW-1:0]  out_rd,
    output logic [3:0]      out_alu_ctrl,
    output logic [1:0]      out_aluop,
    output logic            out_alusrc,
    output logic            out_mem2reg,
    output logic            out_regwr,
    output logic            out_memrd,
    output logic            out_memwr,
    output logic            out_branch,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [RAW-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    ctrl_t           dec, out_ctrl;
    logic            hz, adv;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[7 +: RAW];
    assign rs1    = in_inst[15 +: RAW];
    assign rs2    = in_inst[20 +: RAW];
    assign dec    = decode_ctrl(in_inst);

    decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LD: imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            OP_ST:         imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            OP_BR:         imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                                  in_inst[30:25], in_inst[11:8], 1'b0};
            default:       imm = '0;
        endcase
    end

    // Load in ID/EX whose destination the incoming instruction reads: data not ready until MEM.
    assign hz = out_valid & out_ctrl.memrd & (out_rd != '0) & in_valid &
                ((uses_rs1(opcode) & (rs1 == out_rd)) | (uses_rs2(opcode) & (rs2 == out_rd)));
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv & !hz & !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_ctrl     <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (adv) begin
            if (hz || !in_valid) begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end else begin
                out_valid    <= 1'b1;
                out_ctrl     <= dec;
                out_rs1_data <= rs1_data;
                out_rs2_data <= rs2_data;
                out_imm      <= imm;
                out_rs1      <= rs1;
                out_rs2      <= rs2;
                out_rd       <= rd;
            end
        end
    end

    assign out_alusrc   = out_ctrl.alusrc;
    assign out_mem2reg  = out_ctrl.mem2reg;
    assign out_regwr    = out_ctrl.regwr;
    assign out_memrd    = out_ctrl.memrd;
    assign out_memwr    = out_ctrl.memwr;
    assign out_branch   = out_ctrl.branch;
    assign out_aluop    = out_ctrl.aluop;
    assign out_alu_ctrl = out_ctrl.alu_ctrl;
    assign out_illegal  = out_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios with literal expectations, then randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_decode_stage_pipe;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int RAW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush, in_valid, in_ready, wb_en, out_valid, out_ready;
    logic [31:0]     in_inst;
    logic [RAW-1:0]  wb_rd, out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] wb_data, out_rs1_data, out_rs2_data, out_imm;
    logic [3:0]      out_alu_ctrl;
    logic [1:0]      out_aluop;
    logic            out_alusrc, out_mem2reg, out_regwr, out_memrd, out_memwr, out_branch, out_illegal;

    decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_alu_ctrl(out_alu_ctrl), .out_aluop(out_aluop),
        .out_alusrc(out_alusrc), .out_mem2reg(out_mem2reg), .out_regwr(out_regwr),
        .out_memrd(out_memrd), .out_memwr(out_memwr), .out_branch(out_branch),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [63:0] d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_ctrl;
        logic [1:0]  aluop;
        logic        alusrc, mem2reg, regwr, memrd, memwr, branch, illegal;
    } exp_t;

    exp_t        st;
    logic [63:0] mref [32];

    function automatic logic [63:0] sext(input logic [12:0] v, input int n);
        return v[n-1] ? (64'(v) - (64'd1 << n)) : 64'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] inst);
        exp_t e;
        logic [2:0] f3;
        e = '0;
        f3 = inst[14:12];
        e.rs1 = inst[19:15];
        e.rs2 = inst[24:20];
        e.rd  = inst[11:7];
        case (inst[6:0])
            7'b0110011: begin e.regwr = 1; e.aluop = 2; e.alu_ctrl = {inst[30], f3}; end
            7'b0010011: begin
                e.regwr = 1; e.alusrc = 1; e.aluop = 2;
                e.alu_ctrl = {inst[30] && (f3 == 3'd5), f3};
                e.imm = sext({1'b0, inst[31:20]}, 12);
            end
            7'b0000011: begin
                e.alusrc = 1; e.mem2reg = 1; e.regwr = 1; e.memrd = 1; e.alu_ctrl = 4'd2;
                e.imm = sext({1'b0, inst[31:20]}, 12);
            end
            7'b0100011: begin
                e.alusrc = 1; e.memwr = 1; e.alu_ctrl = 4'd2;
                e.imm = sext({1'b0, inst[31:25], inst[11:7]}, 12);
            end
            7'b1100011: begin
                e.branch = 1; e.aluop = 1; e.alu_ctrl = 4'd6;
                e.imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
            end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic [63:0] rdreg(input logic [4:0] a);
        if (a == 0) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_rd == a) return wb_data;
`endif
        return mref[a];
    endfunction

    function automatic logic model_hz();
        logic [6:0] op;
        logic u1, u2;
        op = in_inst[6:0];
        u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return st.valid && st.memrd && st.rd != 0 && in_valid &&
               ((u1 && in_inst[19:15] == st.rd) || (u2 && in_inst[24:20] == st.rd));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t n;
        if (!rst_n) begin
            st = '0;
            for (int i = 0; i < 32; i++) mref[i] = 64'd0;
        end else begin
            if (flush) st = '0;
            else if (!st.valid || out_ready) begin
                if (in_valid && !model_hz()) begin
                    n = ref_decode(in_inst);
                    n.d1 = rdreg(in_inst[19:15]);
                    n.d2 = rdreg(in_inst[24:20]);
                    n.valid = 1;
                    st = n;
                end else st = '0;
            end
            if (wb_en && wb_rd != 0) mref[wb_rd] = wb_data;
        end
    end

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("in_ready", in_ready, (!st.valid || out_ready) && !model_hz() && !flush);
            chk("out_valid", out_valid, st.valid);
            chk("ctrl", {out_alusrc, out_mem2reg, out_regwr, out_memrd, out_memwr, out_branch,
                         out_aluop, out_alu_ctrl, out_illegal},
                        {st.alusrc, st.mem2reg, st.regwr, st.memrd, st.memwr, st.branch,
                         st.aluop, st.alu_ctrl, st.illegal});
            if (st.valid) begin
                chk("rs1_data", out_rs1_data, st.d1);
                chk("rs2_data", out_rs2_data, st.d2);
                chk("imm", out_imm, st.imm);
                chk("regidx", {out_rs1, out_rs2, out_rd}, {st.rs1, st.rs2, st.rd});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
    endtask

    logic [63:0] exp_byp;

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_inst = 0; out_ready = 1;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_regwr", out_regwr, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_rs1_data", out_rs1_data, 0);
        rst_n = 1;
        run = 1;
        tick();

        // x5 = 0x1234, then add x7,x5,x0
        wb_en = 1; wb_rd = 5; wb_data = 64'h1234;
        tick();
        wb_en = 0;
        issue(32'h000283B3);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_rs1_data", out_rs1_data, 64'h1234);
        chk("add_regwr", out_regwr, 1);
        chk("add_aluop", out_aluop, 2'b10);
        chk("add_alu_ctrl", out_alu_ctrl, 4'b0000);
        chk("add_rd", out_rd, 7);

        // ld x6,8(x1); add x7,x6,x2 -> one bubble
        issue(32'h0080B303);
        tick();
        chk("ld_memrd", out_memrd, 1);
        chk("ld_imm", out_imm, 64'd8);
        issue(32'h002303B3);
        #1;
        chk("lu_in_ready_stall", in_ready, 0);
        tick();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_regwr", out_regwr, 0);
        chk("lu_in_ready_free", in_ready, 1);
        tick();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rs1", out_rs1, 6);
        in_valid = 0;
        tick();

        // sd x2,-4(x1); beq x1,x2,-8
        issue(32'hFE20BE23);
        tick();
        chk("sd_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sd_memwr", out_memwr, 1);
        chk("sd_regwr", out_regwr, 0);
        issue(32'hFE208CE3);
        tick();
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_branch", out_branch, 1);
        chk("beq_alu_ctrl", out_alu_ctrl, 4'b0110);
        in_valid = 0;
        tick();

        // backpressure hold, then flush while stalled
        out_ready = 0;
        issue(32'h000283B3);
        tick();
        chk("hold_load_valid", out_valid, 1);
        issue(32'h00018413);
        #1;
        chk("hold_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_rs1_data", out_rs1_data, 64'h1234);
            chk("hold_rd", out_rd, 7);
        end
        flush = 1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();

        // WB to x3 in the same cycle addi x8,x3,0 is decoded
`ifdef DECODE_WB_BYPASS_EN
        exp_byp = 64'hAA;
`else
        exp_byp = 64'h0;
`endif
        issue(32'h00018413);
        wb_en = 1; wb_rd = 3; wb_data = 64'hAA;
        tick();
        chk("wb_same_cycle_rs1", out_rs1_data, exp_byp);
        wb_en = 0;
        tick();
        chk("wb_later_rs1", out_rs1_data, 64'hAA);

        // illegal opcode
        issue(32'h0000007F);
        tick();
        chk("ill_flag", out_illegal, 1);
        chk("ill_valid", out_valid, 1);
        chk("ill_ctrl_zero", {out_alusrc, out_mem2reg, out_regwr, out_memrd, out_memwr,
                              out_branch, out_aluop, out_alu_ctrl}, 0);

        // x0 write ignored
        in_valid = 0;
        wb_en = 1; wb_rd = 0; wb_data = 64'h55;
        tick();
        wb_en = 0;
        issue(32'h000003B3);
        tick();
        chk("x0_reads_zero", out_rs1_data, 0);
        in_valid = 0;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            int op;
            if (i == 1500) begin
                rst_n = 0;
                #2;
                tick();
                rst_n = 1;
            end
            r  = $urandom;
            op = $urandom_range(0, 5);
            case (op)
                0: r[6:0] = 7'b0110011;
                1: r[6:0] = 7'b0010011;
                2: r[6:0] = 7'b0000011;
                3: r[6:0] = 7'b0100011;
                4: r[6:0] = 7'b1100011;
                default: r[6:0] = 7'b1111111;
            endcase
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            in_inst   = r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = {$urandom, $urandom};
            tick();
        end
        in_valid = 0; wb_en = 0; flush = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
